// File: rtl/plic_lite_ctrl_pkg.sv
// rtl/plic_lite_ctrl_pkg.sv - shared constants, register offsets and gateway state type
// for the single-context platform interrupt controller.
package plic_lite_ctrl_pkg;

  localparam int PLIC_NUM_SOURCES = 32;
  localparam int PLIC_PRIO_WIDTH  = 3;

  localparam logic [11:0] PLIC_PRIO_OFFSET      = 12'h000;
  localparam logic [11:0] PLIC_PENDING_OFFSET   = 12'h080;
  localparam logic [11:0] PLIC_ENABLE_OFFSET    = 12'h100;
  localparam logic [11:0] PLIC_THRESHOLD_OFFSET = 12'h180;
  localparam logic [11:0] PLIC_CLAIM_OFFSET     = 12'h184;

  // Static platform line map; line 0 is reserved and never arbitrated.
  localparam int PLIC_GPIO_IN_INTERRUPT = 1;
  localparam int PLIC_TIM0_INTERRUPT    = 2;
  localparam int PLIC_TIM1_INTERRUPT    = 3;
  localparam int PLIC_UART_INTERRUPT    = 4;
  localparam int PLIC_CMAC_INTERRUPT    = 5;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_INFLIGHT
  } plic_gw_state_t;

endpackage

// File: rtl/plic_lite_ctrl_gateway.sv
// rtl/plic_lite_ctrl_gateway.sv - per-source gateway: latches a level request and
// masks the source from claim until the matching complete.
module plic_gateway
  import plic_lite_ctrl_pkg::*;
(
  input  logic clock_i,
  input  logic reset_ni,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  plic_gw_state_t state_q, state_d;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= GW_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GW_IDLE:     if (src_i)      state_d = GW_PENDING;
      GW_PENDING:  if (claim_i)    state_d = GW_INFLIGHT;
      GW_INFLIGHT: if (complete_i) state_d = GW_IDLE;
      default:                     state_d = GW_IDLE;
    endcase
  end

  assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/plic_lite_ctrl.sv
// rtl/plic_lite_ctrl.sv - top: register port, gateway array, priority arbiter tree
// and claim/complete handshake driving the core external interrupt.
module plic_lite_ctrl
  import plic_lite_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = PLIC_NUM_SOURCES,
  parameter int PRIO_WIDTH  = PLIC_PRIO_WIDTH
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  input  logic                   reg_req_i,
  input  logic                   reg_we_i,
  input  logic [11:0]            reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  output logic                   reg_gnt_o,
  output logic                   reg_rvalid_o,
  output logic [31:0]            reg_rdata_o,
  output logic                   eip_o
);

  localparam int ID_WIDTH = $clog2(NUM_SOURCES);

  logic [PRIO_WIDTH-1:0]  prio_q [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] enable_q;
  logic [PRIO_WIDTH-1:0]  threshold_q;
  logic [ID_WIDTH-1:0]    best_id_q, best_id_d;
  logic [NUM_SOURCES-1:0] pending;
  logic                   rvalid_q;
  logic [31:0]            rdata_q, rdata_d;
  logic                   unused_src0;

  logic rd, wr, prio_sel, claim, complete;
  logic [ID_WIDTH-1:0] prio_idx, complete_id;

  assign rd          = reg_req_i & ~reg_we_i;
  assign wr          = reg_req_i & reg_we_i;
  assign prio_sel    = (reg_addr_i < PLIC_PENDING_OFFSET) && (reg_addr_i[1:0] == 2'b00);
  assign prio_idx    = reg_addr_i[ID_WIDTH+1:2];
  assign claim       = rd && (reg_addr_i == PLIC_CLAIM_OFFSET);
  assign complete    = wr && (reg_addr_i == PLIC_CLAIM_OFFSET);
  assign complete_id = reg_wdata_i[ID_WIDTH-1:0];
  assign unused_src0 = irq_src_i[0];

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_SOURCES; i++) prio_q[i] <= '0;
      enable_q    <= '0;
      threshold_q <= '0;
    end else if (wr) begin
      if (prio_sel && (prio_idx != '0)) prio_q[prio_idx] <= reg_wdata_i[PRIO_WIDTH-1:0];
      if (reg_addr_i == PLIC_ENABLE_OFFSET) enable_q <= {reg_wdata_i[NUM_SOURCES-1:1], 1'b0};
      if (reg_addr_i == PLIC_THRESHOLD_OFFSET) threshold_q <= reg_wdata_i[PRIO_WIDTH-1:0];
    end
  end

  assign pending[0] = 1'b0;
  for (genvar i = 1; i < NUM_SOURCES; i++) begin : g_gw
    plic_gateway u_gw (
      .clock_i    (clock_i),
      .reset_ni   (reset_ni),
      .src_i      (irq_src_i[i]),
      .claim_i    (claim && (best_id_q == ID_WIDTH'(i))),
      .complete_i (complete && (complete_id == ID_WIDTH'(i))),
      .pending_o  (pending[i])
    );
  end

  // Pairwise tree; the lower-ID side keeps the node on equal priority.
  always_comb begin
    logic [PRIO_WIDTH-1:0] node_prio [NUM_SOURCES];
    logic [ID_WIDTH-1:0]   node_id   [NUM_SOURCES];
    for (int i = 0; i < NUM_SOURCES; i++) begin
      node_id[i]   = ID_WIDTH'(i);
      node_prio[i] = (pending[i] && enable_q[i] && (prio_q[i] > threshold_q)) ? prio_q[i] : '0;
    end
    for (int lvl = 0; lvl < ID_WIDTH; lvl++) begin
      for (int k = 0; k < NUM_SOURCES; k += (2 << lvl)) begin
        if (node_prio[k + (1 << lvl)] > node_prio[k]) begin
          node_prio[k] = node_prio[k + (1 << lvl)];
          node_id[k]   = node_id[k + (1 << lvl)];
        end
      end
    end
    best_id_d = (node_prio[0] != '0) ? node_id[0] : '0;
  end

  always_comb begin
    rdata_d = '0;
    if (prio_sel) begin
      rdata_d[PRIO_WIDTH-1:0] = prio_q[prio_idx];
    end else begin
      case (reg_addr_i)
        PLIC_PENDING_OFFSET:   rdata_d[NUM_SOURCES-1:0] = pending;
        PLIC_ENABLE_OFFSET:    rdata_d[NUM_SOURCES-1:0] = enable_q;
        PLIC_THRESHOLD_OFFSET: rdata_d[PRIO_WIDTH-1:0]  = threshold_q;
        PLIC_CLAIM_OFFSET:     rdata_d[ID_WIDTH-1:0]    = best_id_q;
        default:               rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      best_id_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      best_id_q <= best_id_d;
      rvalid_q  <= reg_req_i;
      rdata_q   <= rd ? rdata_d : '0;
    end
  end

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign eip_o        = (best_id_q != '0);

endmodule
